// File: rtl/semaforo_multi.sv
// Round-robin traffic-light controller for N_WAYS ways with a latched pedestrian request and walk phase.
// Optional night blink mode (adds the noite input) is enabled by defining SEMAFORO_NOITE_EN.
module semaforo_multi #(
    parameter int N_WAYS      = 2,
    parameter int CNT_W       = 8,
    parameter int T_VERDE     = 4,
    parameter int T_MIN_VERDE = 2,
    parameter int T_AMARELO   = 2,
    parameter int T_LIMPEZA   = 1,
    parameter int T_PEDESTRE  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bt,
`ifdef SEMAFORO_NOITE_EN
    input  logic                noite,
`endif
    output logic [3*N_WAYS-1:0] L,
    output logic                walk,
    output logic                bt_pend
);

    localparam int WW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    localparam logic [CNT_W-1:0] FIM_VERDE    = CNT_W'(T_VERDE - 1);
    localparam logic [CNT_W-1:0] MIN_VERDE    = CNT_W'(T_MIN_VERDE - 1);
    localparam logic [CNT_W-1:0] FIM_AMARELO  = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] FIM_PEDESTRE = CNT_W'(T_PEDESTRE - 1);
    localparam logic [CNT_W-1:0] FIM_LIMPEZA  = CNT_W'((T_LIMPEZA > 0) ? T_LIMPEZA - 1 : 0);

    typedef enum logic [1:0] {
        VERDE    = 2'd0,
        AMARELO  = 2'd1,
        PEDESTRE = 2'd2,
        LIMPEZA  = 2'd3
    } fase_t;

    fase_t             fase_q, fase_d;
    logic [WW-1:0]     w_q, w_d, w_prox;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              muda;

`ifdef SEMAFORO_NOITE_EN
    localparam logic [CNT_W:0] FIM_PISCA  = (CNT_W+1)'(2*T_AMARELO - 1);
    localparam logic [CNT_W:0] MEIO_PISCA = (CNT_W+1)'(T_AMARELO);

    logic             noite_q;
    logic [CNT_W:0]   pisca_q;
    logic             pisca_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noite_q <= 1'b0;
            pisca_q <= '0;
        end else begin
            noite_q <= noite;
            pisca_q <= (pisca_q == FIM_PISCA) ? '0 : pisca_q + 1'b1;
        end
    end

    assign pisca_on = (pisca_q >= MEIO_PISCA);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fase_q <= VERDE;
            w_q    <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            fase_q <= fase_d;
            w_q    <= w_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign w_prox = (w_q == WW'(N_WAYS - 1)) ? '0 : w_q + 1'b1;

    always_comb begin
        fase_d = fase_q;
        w_d    = w_q;
        muda   = 1'b0;
        case (fase_q)
            VERDE: begin
                // A pending request may cut green only after the minimum green time.
                if ((cnt_q == FIM_VERDE) || (pend_q && (cnt_q >= MIN_VERDE))) begin
                    fase_d = AMARELO;
                    muda   = 1'b1;
                end
            end
            AMARELO: begin
                if (cnt_q == FIM_AMARELO) begin
                    muda = 1'b1;
                    if (pend_q) begin
                        fase_d = PEDESTRE;
                    end else if (T_LIMPEZA > 0) begin
                        fase_d = LIMPEZA;
                    end else begin
                        fase_d = VERDE;
                        w_d    = w_prox;
                    end
                end
            end
            PEDESTRE: begin
                if (cnt_q == FIM_PEDESTRE) begin
                    muda = 1'b1;
                    if (T_LIMPEZA > 0) begin
                        fase_d = LIMPEZA;
                    end else begin
                        fase_d = VERDE;
                        w_d    = w_prox;
                    end
                end
            end
            default: begin
                if (cnt_q == FIM_LIMPEZA) begin
                    muda   = 1'b1;
                    fase_d = VERDE;
                    w_d    = w_prox;
                end
            end
        endcase

        cnt_d = muda ? '0 : cnt_q + 1'b1;

        // Entering the walk phase consumes the request, even if bt is high on that edge.
        if (muda && (fase_d == PEDESTRE)) begin
            pend_d = 1'b0;
        end else if (bt && (fase_q != PEDESTRE)) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

`ifdef SEMAFORO_NOITE_EN
        // Held at VERDE(0) through night mode and its trailing edge so day resumes with a full green.
        if (noite || noite_q) begin
            fase_d = VERDE;
            w_d    = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end
`endif
    end

    always_comb begin
        L    = '0;
        walk = (fase_q == PEDESTRE);
        for (int k = 0; k < N_WAYS; k++) begin
            L[3*k +: 3] = 3'b100;
            if (WW'(k) == w_q) begin
                if (fase_q == VERDE) begin
                    L[3*k +: 3] = 3'b001;
                end else if (fase_q == AMARELO) begin
                    L[3*k +: 3] = 3'b010;
                end
            end
`ifdef SEMAFORO_NOITE_EN
            if (noite_q) begin
                L[3*k +: 3] = pisca_on ? 3'b010 : 3'b100;
            end
`endif
        end
`ifdef SEMAFORO_NOITE_EN
        if (noite_q) begin
            walk = 1'b0;
        end
`endif
    end

    assign bt_pend = pend_q;

endmodule
